// File: rtl/serial_mult32.sv
// Multi-cycle shift-add multiplier for MIPS MULT/MULTU; one partial product per clock,
// sign applied once at the end, result held in HI/LO until the next completed operation.
module serial_mult32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mag_a_q;
  logic [WIDTH-1:0] acc_hi_q;
  // Multiplier bits shift out of the bottom while product bits shift in from the top.
  logic [WIDTH-1:0] mult_q;
  logic             neg_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] acc;

  assign sum = {1'b0, acc_hi_q} + {1'b0, (mult_q[0] ? mag_a_q : '0)};
  assign acc = {acc_hi_q, mult_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start ? StCalc : StIdle;
      StCalc:  state_d = (cnt_q == LastCnt) ? StFix : StCalc;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_q  <= '0;
      acc_hi_q <= '0;
      mult_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mag_a_q  <= (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
            mult_q   <= (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
            neg_q    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_hi_q <= '0;
            cnt_q    <= '0;
          end
        end
        StCalc: begin
          acc_hi_q <= sum[WIDTH:1];
          mult_q   <= {sum[0], mult_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
        end
        StFix: begin
          {HI, LO} <= neg_q ? (~acc + 1'b1) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult32.sv
// Directed bench for serial_mult32: latency, signed/unsigned products, ignored starts,
// mid-operation reset and idle stability.
module tb_serial_mult32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  serial_mult32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then wait for done with a bounded cycle budget.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    is_signed = s;
    A         = a;
    B         = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    A         = $urandom;
    B         = $urandom;
    is_signed = ~s;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_hi"}, {32'd0, HI}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, LO}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {busy, done, 30'd0, HI}, 64'd0);
    check("reset_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_3x5", 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    run_op("mult_m7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("multu_m7x6", 1'b0, 32'hFFFF_FFF9, 32'd6, 32'h0000_0005, 32'hFFFF_FFD6);
    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Starts at k+5 and in DONE must be ignored.
    @(negedge clk);
    is_signed = 1'b0;
    A = 32'd2;
    B = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy_k5", {63'd0, busy}, 64'd1);
    n = 5;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ign_latency", 64'(n), 64'd33);
    check("ign_result", {HI, LO}, 64'd4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_after_done", {62'd0, busy, done}, 64'd0);
    @(posedge clk);
    #1;
    check("ign_no_queue", {62'd0, busy, done}, 64'd0);
    check("ign_hold", {HI, LO}, 64'd4);

    // Reset in the middle of CALC.
    run_op("pre_rst", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000_000F);
    @(negedge clk);
    A = 32'd7;
    B = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_abort_ctl", {62'd0, busy, done}, 64'd0);
    check("rst_abort_res", {HI, LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 1'b1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    // Idle stability while inputs toggle.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      is_signed = i[0];
      @(posedge clk);
      #1;
      check("idle_ctl", {62'd0, busy, done}, 64'd0);
      check("idle_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFD6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
